fir_out_buf: RTL
================

FIR_OUT_BUF -- requirements
Module: fir_out_buf

Interface
REQ-001 SHALL have parameter pDATA_WIDTH, default 32, the stream data width.
REQ-002 SHALL have parameter DEPTH, default 4, the FIFO entry count (power of 2, >=2).
REQ-003 SHALL have parameter SAT_W, default 16, the saturation width used under FIR_OUT_SAT_EN.
REQ-004 SHALL have port axis_clk  in  1  clock.
REQ-005 SHALL have port axis_rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports s_tvalid/s_tdata/s_tlast  in  1/pDATA_WIDTH/1  y[n] stream from FIR sm_* outputs.
REQ-007 SHALL have port s_tready  out  1  upstream ready.
REQ-008 SHALL have ports m_tvalid/m_tdata/m_tlast  out  1/pDATA_WIDTH/1  downstream y[n] stream.
REQ-009 SHALL have port m_tready  in  1  downstream ready.
REQ-010 SHALL have port cfg_start  in  1  one-cycle arm pulse.
REQ-011 SHALL have port cfg_len  in  32  expected sample count, sampled on cfg_start.
REQ-012 SHALL have ports sample_cnt/len_err/done/sat_seen  out  32/1/1/1  status.

Function
REQ-013 SHALL run FSM IDLE->RUN on cfg_start, RUN->DONE on output handshake with m_tlast=1, DONE->IDLE next cycle.
REQ-014 SHALL ignore cfg_start outside IDLE.
REQ-015 SHALL latch cfg_len and clear sample_cnt and len_err when cfg_start is accepted.
REQ-016 SHALL drive s_tready = (state==RUN) && !full, from registered state only.
REQ-017 SHALL store {s_tlast, processed s_tdata} on s_tvalid&&s_tready.
REQ-018 SHALL drive m_tvalid = !empty; first data visible one cycle after push into empty FIFO (no bypass).
REQ-019 SHALL pop on m_tvalid&&m_tready; push and pop in the same cycle leave occupancy unchanged.
REQ-020 SHALL wrap read/write pointers modulo DEPTH; full/empty derived from an occupancy counter 0..DEPTH.
REQ-021 SHALL hold m_tdata/m_tlast stable while m_tvalid=1 and m_tready=0.
REQ-022 SHALL increment sample_cnt per output handshake, saturating at 2^32-1.
REQ-023 SHALL drive m_tlast = stored tlast OR (latched len!=0 AND sample_cnt==len-1).
REQ-024 SHALL set len_err (sticky until next accepted cfg_start) when stored tlast pops at sample_cnt!=len-1 while len!=0.
REQ-025 SHALL pulse done high for exactly the DONE cycle.
REQ-026 SHALL, with len=0, terminate only on stored tlast and never set len_err.

Reset
REQ-027 SHALL on reset: state IDLE, FIFO empty, pointers 0, s_tready=0, m_tvalid=0, m_tdata=0, m_tlast=0, sample_cnt=0, len_err=0, done=0, sat_seen=0, latched len=0.
REQ-028 SHALL discard FIFO contents on reset asserted mid-transfer; no output after deassertion until a new cfg_start.

Configuration
REQ-029 SHALL, with FIR_OUT_SAT_EN defined, clamp signed s_tdata to [-2^(SAT_W-1), 2^(SAT_W-1)-1], sign-extend to pDATA_WIDTH, and set sticky sat_seen on any clamp (cleared by cfg_start).
REQ-030 SHALL, without FIR_OUT_SAT_EN, pass s_tdata unmodified and tie sat_seen to 0.

Structure
REQ-031 SHALL place FSM state encoding (IDLE/RUN/DONE) and the saturation helper function in package fir_pkg.
REQ-032 SHALL implement storage as sub-module fir_out_fifo (DEPTH x (pDATA_WIDTH+1), count-based full/empty).

Verification
REQ-033 SHALL verify: cfg_start len=4, push 4 samples (last on 4th), m_tready=1 -> 4 outputs, m_tlast on 4th, done pulse, len_err=0, sample_cnt=4.
REQ-034 SHALL verify: m_tready=0, push 5 with DEPTH=4 -> s_tready low after 4th accept; release m_tready -> 5 outputs in order, no loss.
REQ-035 SHALL verify: len=3, s_tlast on 2nd sample -> len_err=1 after 2nd pop, FSM DONE then IDLE.
REQ-036 SHALL verify: len=2, no s_tlast -> m_tlast forced on 2nd output, len_err=0.
REQ-037 SHALL verify (FIR_OUT_SAT_EN, SAT_W=16): inputs 40000, -40000, 100 -> outputs 32767, -32768, 100, sat_seen=1.
REQ-038 SHALL verify: reset asserted with 2 entries queued -> m_tvalid=0 next cycle, stays 0 until new cfg_start and push.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared types and helpers for the FIR output buffer: FSM state encoding and
// the signed saturation function used when FIR_OUT_SAT_EN is defined.
package fir_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } fir_state_e;

   // Clamps a sign-extended 64-bit sample into the signed range of sat_w bits
   function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] v,
                                                    input int sat_w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (sat_w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (sat_w - 1));
      if (v > hi)
         return hi;
      else if (v < lo)
         return lo;
      else
         return v;
   endfunction

endpackage

// File: rtl/fir_out_fifo.sv
// Count-based circular FIFO holding {tlast, data}; read data is forced to zero
// while empty so the downstream bus idles at a known value.
module fir_out_fifo #(
   parameter int WIDTH = 33,
   parameter int DEPTH = 4
) (
   input  logic             axis_clk,
   input  logic             axis_rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign rd_data = empty ? '0 : mem[rd_ptr];

   // DEPTH is a power of two, so pointer wrap falls out of the natural overflow
   always_ff @(posedge axis_clk or negedge axis_rst_n) begin
      if (!axis_rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)
            count <= count + 1'b1;
         else if (!do_push && do_pop)
            count <= count - 1'b1;
      end
   end

   always_ff @(posedge axis_clk) begin
      if (do_push)
         mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/fir_out_buf.sv
// Output buffer for the FIR y[n] stream: FIFO, run FSM, length tracking and status.
// Optional input saturation is enabled by defining FIR_OUT_SAT_EN.
module fir_out_buf
   import fir_pkg::*;
#(
   parameter int pDATA_WIDTH = 32,
   parameter int DEPTH       = 4,
   parameter int SAT_W       = 16
) (
   input  logic                   axis_clk,
   input  logic                   axis_rst_n,
   input  logic                   s_tvalid,
   input  logic [pDATA_WIDTH-1:0] s_tdata,
   input  logic                   s_tlast,
   output logic                   s_tready,
   output logic                   m_tvalid,
   output logic [pDATA_WIDTH-1:0] m_tdata,
   output logic                   m_tlast,
   input  logic                   m_tready,
   input  logic                   cfg_start,
   input  logic [31:0]            cfg_len,
   output logic [31:0]            sample_cnt,
   output logic                   len_err,
   output logic                   done,
   output logic                   sat_seen
);

   fir_state_e             state;
   logic [31:0]            len_q;
   logic                   full;
   logic                   empty;
   logic                   push;
   logic                   pop;
   logic                   start_ok;
   logic                   rd_last;
   logic                   cnt_at_last;
   logic [pDATA_WIDTH-1:0] proc_data;

   assign start_ok    = (state == IDLE) && cfg_start;
   assign s_tready    = (state == RUN) && !full;
   assign push        = s_tvalid && s_tready;
   assign m_tvalid    = !empty;
   assign pop         = m_tvalid && m_tready;
   assign cnt_at_last = (len_q != 32'd0) && (sample_cnt == len_q - 32'd1);
   assign m_tlast     = rd_last || (m_tvalid && cnt_at_last);
   assign done        = (state == DONE);

`ifdef FIR_OUT_SAT_EN
   logic signed [63:0] wide_in;
   logic signed [63:0] wide_sat;
   logic               clamp_hit;

   assign wide_in   = 64'(signed'(s_tdata));
   assign wide_sat  = sat_clamp(wide_in, SAT_W);
   assign clamp_hit = (wide_sat != wide_in);
   assign proc_data = wide_sat[pDATA_WIDTH-1:0];

   // Sticky clamp indicator, cleared only by the next accepted start
   always_ff @(posedge axis_clk or negedge axis_rst_n) begin
      if (!axis_rst_n)
         sat_seen <= 1'b0;
      else if (start_ok)
         sat_seen <= 1'b0;
      else if (push && clamp_hit)
         sat_seen <= 1'b1;
   end
`else
   logic unused_sat_w;

   assign proc_data    = s_tdata;
   assign sat_seen     = 1'b0;
   assign unused_sat_w = |32'(SAT_W);
`endif

   fir_out_fifo #(
      .WIDTH(pDATA_WIDTH + 1),
      .DEPTH(DEPTH)
   ) u_fifo (
      .axis_clk  (axis_clk),
      .axis_rst_n(axis_rst_n),
      .push      (push),
      .wr_data   ({s_tlast, proc_data}),
      .pop       (pop),
      .rd_data   ({rd_last, m_tdata}),
      .full      (full),
      .empty     (empty)
   );

   // A run ends on whichever comes first: stored tlast or the length-forced last
   always_ff @(posedge axis_clk or negedge axis_rst_n) begin
      if (!axis_rst_n) begin
         state <= IDLE;
         len_q <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               if (cfg_start) begin
                  state <= RUN;
                  len_q <= cfg_len;
               end
            end
            RUN: begin
               if (pop && m_tlast)
                  state <= DONE;
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // len_err flags an upstream tlast that disagrees with the programmed length
   always_ff @(posedge axis_clk or negedge axis_rst_n) begin
      if (!axis_rst_n) begin
         sample_cnt <= 32'd0;
         len_err    <= 1'b0;
      end else if (start_ok) begin
         sample_cnt <= 32'd0;
         len_err    <= 1'b0;
      end else begin
         if (pop && (sample_cnt != '1))
            sample_cnt <= sample_cnt + 32'd1;
         if (pop && rd_last && (len_q != 32'd0) && !cnt_at_last)
            len_err <= 1'b1;
      end
   end

endmodule
